// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Accepts a little-endian byte stream
// (length word, data words, checksum word), writes the data words into
// instruction memory and releases the core only after the checksum verifies.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   // Largest legal image length in words (memory capacity).
   localparam logic [32:0] L_CAP = 33'd1 << ADDR_W;

   state_t            r_state;
   logic [1:0]        r_bcnt;
   logic [23:0]       r_part;
   logic [ADDR_W:0]   r_len;
   logic [31:0]       r_sum;
   logic              r_in_ready;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_core_rst;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic [ADDR_W:0]   r_words;

   logic              w_idle_like;
   logic              w_go;
   logic              w_accept;
   logic              w_last;
   logic [31:0]       w_word;
   logic              w_len_big;
   logic              w_len_zero;
   logic [ADDR_W:0]   w_words_nxt;

   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
   assign w_go        = start && w_idle_like;
   assign w_accept    = in_valid && r_in_ready;
   assign w_last      = w_accept && (r_bcnt == 2'd3);
   // The 4th byte of a group is used straight from the input so the word is
   // complete on the same edge it is accepted.
   assign w_word      = {in_data, r_part};
   assign w_len_big   = {1'b0, w_word} > L_CAP;
   assign w_len_zero  = (w_word == 32'd0);
   assign w_words_nxt = r_words + {{ADDR_W{1'b0}}, 1'b1};

   assign in_ready     = r_in_ready;
   assign imem_we      = r_we;
   assign imem_addr    = r_addr;
   assign imem_wdata   = r_wdata;
   assign core_rst     = r_core_rst;
   assign busy         = r_busy;
   assign done         = r_done;
   assign error        = r_error;
   assign words_loaded = r_words;

   // Byte assembler: places each accepted byte at its little-endian lane.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bcnt <= 2'd0;
         r_part <= 24'd0;
      end else if (w_go) begin
         r_bcnt <= 2'd0;
      end else if (w_accept) begin
         r_bcnt <= r_bcnt + 2'd1;
         case (r_bcnt)
            2'd0:    r_part[7:0]   <= in_data;
            2'd1:    r_part[15:8]  <= in_data;
            2'd2:    r_part[23:16] <= in_data;
            default: ;
         endcase
      end
   end

   // Load sequencer: length / data / checksum phases with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_sum      <= 32'd0;
         r_in_ready <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
         r_core_rst <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_words    <= '0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  r_state    <= S_LEN;
                  r_words    <= '0;
                  r_sum      <= 32'd0;
                  r_core_rst <= 1'b1;
                  r_error    <= 1'b0;
                  r_done     <= 1'b0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            S_LEN: begin
               if (w_last) begin
                  if (w_len_big) begin
                     r_state    <= S_ERROR;
                     r_error    <= 1'b1;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b0;
                  end else if (w_len_zero) begin
                     r_state <= S_CSUM;
                     r_len   <= '0;
                  end else begin
                     r_state <= S_DATA;
                     r_len   <= w_word[ADDR_W:0];
                  end
               end
            end
            S_DATA: begin
               if (w_last) begin
                  r_we    <= 1'b1;
                  r_addr  <= r_words[ADDR_W-1:0];
                  r_wdata <= w_word;
                  r_words <= w_words_nxt;
                  r_sum   <= r_sum + w_word;
                  if (w_words_nxt == r_len) begin
                     r_state <= S_CSUM;
                  end
               end
            end
            S_CSUM: begin
               if (w_last) begin
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b0;
                  if (w_word == r_sum) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_core_rst <= 1'b0;
                  end else begin
                     r_state <= S_ERROR;
                     r_error <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized bench for imem_loader.
module tb_imem_loader;
   localparam int ADDR_W = 10;
   localparam logic [31:0] CAPW = 32'd1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'd0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_rst(core_rst), .busy(busy), .done(done),
      .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]        img[$];
   logic [ADDR_W-1:0] act_addr[$];
   logic [31:0]       act_data[$];
   logic [ADDR_W-1:0] exp_addr[$];
   logic [31:0]       exp_data[$];

   typedef struct {
      string       nm;
      logic [31:0] n;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] cs;
      int          ndw;
      bit          send_cs;
      bit          gaps;
      bit          exp_d;
      bit          exp_e;
      int          exp_wl;
      logic [31:0] exp_d0;
      logic [31:0] exp_d1;
   } vec_t;

   vec_t vt[6];

   // Record every memory write the DUT issues.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         act_addr.push_back(imem_addr);
         act_data.push_back(imem_wdata);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(string nm, logic [31:0] n, logic [31:0] w0, logic [31:0] w1,
                               logic [31:0] cs, int ndw, bit send_cs, bit gaps, bit ed, bit ee,
                               int ewl, logic [31:0] d0, logic [31:0] d1);
      vec_t v;
      v.nm = nm; v.n = n; v.w0 = w0; v.w1 = w1; v.cs = cs; v.ndw = ndw;
      v.send_cs = send_cs; v.gaps = gaps; v.exp_d = ed; v.exp_e = ee;
      v.exp_wl = ewl; v.exp_d0 = d0; v.exp_d1 = d1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push32(input logic [31:0] w);
      for (int k = 0; k < 4; k++) img.push_back(w[8*k +: 8]);
   endtask

   // Reference: derive expected writes and outcome directly from the byte image.
   task automatic model(output bit d, output bit e, output int wl);
      logic [31:0] n, sum, w, cs;
      exp_addr.delete(); exp_data.delete();
      n = {img[3], img[2], img[1], img[0]};
      d = 1'b0; e = 1'b0; wl = 0; sum = 32'd0;
      if (n > CAPW) begin
         e = 1'b1;
         return;
      end
      for (int i = 0; i < int'(n); i++) begin
         w = {img[4*i+7], img[4*i+6], img[4*i+5], img[4*i+4]};
         exp_addr.push_back(ADDR_W'(i));
         exp_data.push_back(w);
         sum = sum + w;
      end
      cs = {img[4*n+7], img[4*n+6], img[4*n+5], img[4*n+4]};
      d = (cs == sum);
      e = !d;
      wl = int'(n);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int cnt;
      int ng;
      if (gaps) begin
         ng = $urandom_range(0, 3);
         for (int k = 0; k < ng; k++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = ($urandom_range(0, 3) == 0);
            @(negedge clk);
         end
         start = ($urandom_range(0, 3) == 0);
      end
      in_valid = 1'b1;
      in_data  = b;
      cnt = 0;
      while (!in_ready && cnt < 50) begin
         @(negedge clk);
         start = 1'b0;
         cnt++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got %0b expected 1", in_ready);
         in_valid = 1'b0;
         start = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic do_load(input string nm, input bit gaps, input bit ed, input bit ee, input int ewl);
      int nmin;
      act_addr.delete(); act_data.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({nm, ".start_busy"}, busy, 1);
      chk({nm, ".start_ready"}, in_ready, 1);
      chk({nm, ".start_core_rst"}, core_rst, 1);
      chk({nm, ".start_error"}, error, 0);
      chk({nm, ".start_done"}, done, 0);
      chk({nm, ".start_words"}, words_loaded, 0);
      foreach (img[i]) send_byte(img[i], gaps);
      repeat (2) @(negedge clk);
      chk({nm, ".done"}, done, ed);
      chk({nm, ".error"}, error, ee);
      chk({nm, ".core_rst"}, core_rst, !ed);
      chk({nm, ".busy"}, busy, 0);
      chk({nm, ".in_ready"}, in_ready, 0);
      chk({nm, ".words_loaded"}, words_loaded, ewl);
      chk({nm, ".nwrites"}, act_addr.size(), exp_addr.size());
      nmin = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
      for (int i = 0; i < nmin; i++) begin
         chk($sformatf("%s.addr%0d", nm, i), act_addr[i], exp_addr[i]);
         chk($sformatf("%s.data%0d", nm, i), act_data[i], exp_data[i]);
      end
   endtask

   task automatic run_vec(input vec_t v);
      img.delete();
      push32(v.n);
      if (v.ndw >= 1) push32(v.w0);
      if (v.ndw >= 2) push32(v.w1);
      if (v.send_cs) push32(v.cs);
      exp_addr.delete(); exp_data.delete();
      for (int i = 0; i < v.exp_wl; i++) begin
         exp_addr.push_back(ADDR_W'(i));
         exp_data.push_back((i == 0) ? v.exp_d0 : v.exp_d1);
      end
      do_load(v.nm, v.gaps, v.exp_d, v.exp_e, v.exp_wl);
   endtask

   initial begin
      bit          d, e;
      int          wl;
      logic [31:0] n, sum, w, cs;
      bit          big;

      vt[0] = mk("nominal", 32'd2, 32'h00500093, 32'h00A00113, 32'h00F001A6, 2, 1, 0,
                 1, 0, 2, 32'h00500093, 32'h00A00113);
      vt[1] = mk("bad_csum", 32'd2, 32'h00500093, 32'h00A00113, 32'h00F001A7, 2, 1, 0,
                 0, 1, 2, 32'h00500093, 32'h00A00113);
      vt[2] = mk("gaps", 32'd2, 32'h00500093, 32'h00A00113, 32'h00F001A6, 2, 1, 1,
                 1, 0, 2, 32'h00500093, 32'h00A00113);
      vt[3] = mk("zero_len", 32'd0, 32'd0, 32'd0, 32'd0, 0, 1, 0,
                 1, 0, 0, 32'd0, 32'd0);
      vt[4] = mk("len_401", 32'h401, 32'd0, 32'd0, 32'd0, 0, 0, 0,
                 0, 1, 0, 32'd0, 32'd0);
      vt[5] = mk("one_word", 32'd1, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 1, 1, 1,
                 1, 0, 1, 32'hDEADBEEF, 32'd0);

      // Reset, then idle stream without start
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst.core_rst", core_rst, 1);
      chk("rst.in_ready", in_ready, 0);
      chk("rst.imem_we", imem_we, 0);
      chk("rst.imem_addr", imem_addr, 0);
      chk("rst.imem_wdata", imem_wdata, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.error", error, 0);
      chk("rst.words_loaded", words_loaded, 0);
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("idle.in_ready", in_ready, 0);
      chk("idle.core_rst", core_rst, 1);
      chk("idle.busy", busy, 0);
      chk("idle.nwrites", act_addr.size(), 0);

      // Table of directed loads
      for (int i = 0; i < 6; i++) run_vec(vt[i]);

      // Reset mid-word, then reload twice (second from DONE)
      act_addr.delete(); act_data.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      img.delete();
      push32(32'd2);
      img.push_back(8'h93);
      img.push_back(8'h00);
      foreach (img[i]) send_byte(img[i], 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst.nwrites", act_addr.size(), 0);
      chk("midrst.imem_we", imem_we, 0);
      chk("midrst.core_rst", core_rst, 1);
      chk("midrst.in_ready", in_ready, 0);
      chk("midrst.busy", busy, 0);
      chk("midrst.words_loaded", words_loaded, 0);
      vt[0].nm = "reload";
      run_vec(vt[0]);
      vt[0].nm = "restart_from_done";
      run_vec(vt[0]);

      // Randomized images against the reference model
      for (int it = 0; it < 25; it++) begin
         img.delete();
         big = ($urandom_range(0, 5) == 0);
         if (big) begin
            n = 32'h401 + $urandom_range(0, 32'h00FFFFFF);
            push32(n);
         end else begin
            n = $urandom_range(0, 6);
            push32(n);
            sum = 32'd0;
            for (int k = 0; k < int'(n); k++) begin
               w = $urandom;
               push32(w);
               sum = sum + w;
            end
            cs = ($urandom_range(0, 1) == 1) ? sum : (sum ^ (32'd1 << $urandom_range(0, 31)));
            push32(cs);
         end
         model(d, e, wl);
         do_load($sformatf("rnd%0d", it), bit'($urandom_range(0, 1)), d, e, wl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
